l1a_match_queue: RTL and testbench

//  Downstream of the trigger-control stage. On every L1A push pulse (GFPUSH), collects the per-CFEB
//  L1A_MATCH bits over a short window and tags them with a 12-bit L1A number.

---
 rtl/l1a_match_queue.sv | 101 ++++++++++
 tb/tb_l1a_match_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1a_match_queue.sv
// l1a_match_queue: per-L1A CFEB match collection window feeding a first-word-fall-through readout queue
module l1a_match_queue #(
    parameter int AW   = 4,
    parameter int MWIN = 3,
    parameter int NW   = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          L1A,
    input  logic [5:0]    L1A_MATCH,
    input  logic          RD_EN,
    output logic [5:0]    DOUT_MATCH,
    output logic [NW-1:0] DOUT_L1ANUM,
    output logic          DOUT_NOMTCH,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT,
    output logic          OVFL,
    output logic [NW-1:0] L1A_CNT
);
    localparam int DEPTH = 2**AW;
    localparam int EW    = 6 + NW;
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t        state, state_n;
    logic [5:0]    acc, acc_n, merged;
    logic [NW-1:0] tag, tag_n, cnt_n;
    logic [2:0]    wcnt, wcnt_n;
    logic          wr, push, pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp;
    always_comb begin
        state_n = state;
        acc_n   = acc;
        tag_n   = tag;
        wcnt_n  = wcnt;
        cnt_n   = L1A_CNT;
        wr      = 1'b0;
        merged  = acc | L1A_MATCH;
        wdata   = {merged, tag};
        if (state == IDLE) begin
            if (L1A) begin
                acc_n  = L1A_MATCH;
                tag_n  = L1A_CNT;
                cnt_n  = L1A_CNT + 1'b1;
                wcnt_n = 3'd1;
                if (MWIN == 1) begin
                    wr    = 1'b1;
                    wdata = {L1A_MATCH, L1A_CNT};
                end else begin
                    state_n = COLLECT;
                end
            end
        end else begin
            acc_n  = merged;
            wcnt_n = wcnt + 3'd1;
            // A new L1A closes the current window early; its match bits land in both entries
            if (L1A) begin
                wr     = 1'b1;
                acc_n  = L1A_MATCH;
                tag_n  = L1A_CNT;
                cnt_n  = L1A_CNT + 1'b1;
                wcnt_n = 3'd1;
            end else if (wcnt == 3'(MWIN - 1)) begin
                wr      = 1'b1;
                state_n = IDLE;
            end
        end
    end
    assign COUNT = wp - rp;
    assign EMPTY = wp == rp;
    assign FULL  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = RD_EN & ~EMPTY;
    assign push  = wr & (~FULL | pop);
    assign {DOUT_MATCH, DOUT_L1ANUM} = EMPTY ? '0 : mem[rp[AW-1:0]];
    assign DOUT_NOMTCH = ~EMPTY & ~|DOUT_MATCH;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            acc     <= '0;
            tag     <= '0;
            wcnt    <= '0;
            L1A_CNT <= '0;
            wp      <= '0;
            rp      <= '0;
            OVFL    <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            tag     <= tag_n;
            wcnt    <= wcnt_n;
            L1A_CNT <= cnt_n;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (wr & ~push) OVFL <= 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST && push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: tb/tb_l1a_match_queue.sv
// tb_l1a_match_queue: scoreboard bench for the L1A match queue (MWIN=3, depth 16, 12-bit tags)
module tb_l1a_match_queue;
    localparam int AW = 4, MWIN = 3, NW = 12;
    logic          CLK = 1'b0, RST = 1'b1, L1A = 1'b0, RD_EN = 1'b0;
    logic [5:0]    L1A_MATCH = '0;
    logic [5:0]    DOUT_MATCH;
    logic [NW-1:0] DOUT_L1ANUM, L1A_CNT;
    logic          DOUT_NOMTCH, EMPTY, FULL, OVFL;
    logic [AW:0]   COUNT;
    int            compared = 0, mismatched = 0;
    logic [17:0]   sb[$];
    logic [17:0]   exp_e;
    logic [NW-1:0] exp_cnt = '0;

    l1a_match_queue #(.AW(AW), .MWIN(MWIN), .NW(NW)) dut (
        .CLK(CLK), .RST(RST), .L1A(L1A), .L1A_MATCH(L1A_MATCH), .RD_EN(RD_EN),
        .DOUT_MATCH(DOUT_MATCH), .DOUT_L1ANUM(DOUT_L1ANUM), .DOUT_NOMTCH(DOUT_NOMTCH),
        .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVFL(OVFL), .L1A_CNT(L1A_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        exp_cnt = '0;
    endtask

    // One isolated L1A with its match bits on the L1A cycle only, then idle for the rest of the gap
    task automatic l1a_event(input logic [5:0] m, input int gap, input bit keep);
        L1A = 1'b1;
        L1A_MATCH = m;
        if (keep) sb.push_back({m, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        tick();
        L1A = 1'b0;
        L1A_MATCH = '0;
        repeat (gap - 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({EMPTY, FULL, OVFL, COUNT, L1A_CNT} !== {1'b1, 1'b0, 1'b0, 5'd0, 12'd0}) begin
            mismatched++;
            $display("FAIL reset_flags got E%b F%b O%b C%0d N%0d want E1 F0 O0 C0 N0", EMPTY, FULL, OVFL, COUNT, L1A_CNT);
        end
        compared++;
        if ({DOUT_MATCH, DOUT_L1ANUM, DOUT_NOMTCH} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_dout got %h/%h/%b want 0", DOUT_MATCH, DOUT_L1ANUM, DOUT_NOMTCH);
        end
    endtask

    task automatic test_single();
        L1A = 1'b1;
        L1A_MATCH = 6'h04;
        sb.push_back({6'h14, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        tick();
        L1A = 1'b0;
        L1A_MATCH = '0;
        tick();
        L1A_MATCH = 6'h10;
        compared++;
        if (EMPTY !== 1'b1) begin
            mismatched++;
            $display("FAIL t1_empty_c2 got %b want 1", EMPTY);
        end
        tick();
        L1A_MATCH = '0;
        compared++;
        if ({EMPTY, COUNT} !== {1'b0, 5'd1}) begin
            mismatched++;
            $display("FAIL t1_c3_state got E%b C%0d want E0 C1", EMPTY, COUNT);
        end
        exp_e = sb.pop_front();
        compared++;
        if ({DOUT_MATCH, DOUT_L1ANUM, DOUT_NOMTCH} !== {exp_e, 1'b0}) begin
            mismatched++;
            $display("FAIL t1_head got %h/%0d want %h/%0d", DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
        end
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        compared++;
        if (EMPTY !== 1'b1) begin
            mismatched++;
            $display("FAIL t1_empty_after_pop got %b want 1", EMPTY);
        end
    endtask

    task automatic test_late_match();
        l1a_event(6'h00, 3, 1'b1);
        L1A_MATCH = 6'h08;
        exp_e = sb.pop_front();
        compared++;
        if ({EMPTY, DOUT_MATCH, DOUT_L1ANUM, DOUT_NOMTCH} !== {1'b0, exp_e, 1'b1}) begin
            mismatched++;
            $display("FAIL t2_head got E%b %h/%0d/%b want E0 %h/%0d/1", EMPTY, DOUT_MATCH, DOUT_L1ANUM, DOUT_NOMTCH, exp_e[17:12], exp_e[11:0]);
        end
        tick();
        L1A_MATCH = '0;
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        repeat (3) tick();
        compared++;
        if (EMPTY !== 1'b1) begin
            mismatched++;
            $display("FAIL t2_no_extra_entry got E%b C%0d want E1", EMPTY, COUNT);
        end
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        L1A = 1'b1;
        L1A_MATCH = 6'h00;
        sb.push_back({6'h01, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        tick();
        L1A_MATCH = 6'h01;
        sb.push_back({6'h01, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        tick();
        L1A = 1'b0;
        L1A_MATCH = '0;
        for (int i = 0; i < 10; i++) begin
            if (COUNT == 5'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL t3_count_timeout got C%0d want 2", COUNT);
        end
        for (int k = 0; k < 2; k++) begin
            exp_e = sb.pop_front();
            compared++;
            if ({EMPTY, DOUT_MATCH, DOUT_L1ANUM} !== {1'b0, exp_e}) begin
                mismatched++;
                $display("FAIL t3_entry%0d got E%b %h/%0d want %h/%0d", k, EMPTY, DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
            end
            RD_EN = 1'b1;
            tick();
            RD_EN = 1'b0;
        end
        compared++;
        if (EMPTY !== 1'b1) begin
            mismatched++;
            $display("FAIL t3_empty got %b want 1", EMPTY);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) l1a_event(6'(i * 5 + 1), 4, i < 16);
        compared++;
        if ({FULL, OVFL, COUNT, L1A_CNT} !== {1'b1, 1'b1, 5'd16, 12'd17}) begin
            mismatched++;
            $display("FAIL t4_full got F%b O%b C%0d N%0d want F1 O1 C16 N17", FULL, OVFL, COUNT, L1A_CNT);
        end
        for (int k = 0; k < 16; k++) begin
            exp_e = sb.pop_front();
            compared++;
            if ({EMPTY, DOUT_MATCH, DOUT_L1ANUM} !== {1'b0, exp_e}) begin
                mismatched++;
                $display("FAIL t4_pop%0d got E%b %h/%0d want %h/%0d", k, EMPTY, DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
            end
            RD_EN = 1'b1;
            tick();
            RD_EN = 1'b0;
        end
        compared++;
        if ({EMPTY, OVFL, COUNT} !== {1'b1, 1'b1, 5'd0}) begin
            mismatched++;
            $display("FAIL t4_drained got E%b O%b C%0d want E1 O1 C0", EMPTY, OVFL, COUNT);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 16; i++) l1a_event(6'(i + 2), 4, 1'b1);
        L1A = 1'b1;
        L1A_MATCH = 6'h3F;
        tick();
        L1A = 1'b0;
        L1A_MATCH = '0;
        tick();
        exp_e = sb.pop_front();
        compared++;
        if ({FULL, DOUT_MATCH, DOUT_L1ANUM} !== {1'b1, exp_e}) begin
            mismatched++;
            $display("FAIL t5_head got F%b %h/%0d want F1 %h/%0d", FULL, DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
        end
        sb.push_back({6'h3F, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        compared++;
        if ({FULL, OVFL, COUNT} !== {1'b1, 1'b0, 5'd16}) begin
            mismatched++;
            $display("FAIL t5_state got F%b O%b C%0d want F1 O0 C16", FULL, OVFL, COUNT);
        end
        for (int k = 0; k < 16; k++) begin
            exp_e = sb.pop_front();
            compared++;
            if ({EMPTY, DOUT_MATCH, DOUT_L1ANUM} !== {1'b0, exp_e}) begin
                mismatched++;
                $display("FAIL t5_pop%0d got E%b %h/%0d want %h/%0d", k, EMPTY, DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
            end
            RD_EN = 1'b1;
            tick();
            RD_EN = 1'b0;
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        RD_EN = 1'b1;
        L1A = 1'b1;
        repeat (4095) tick();
        L1A = 1'b0;
        repeat (5) tick();
        RD_EN = 1'b0;
        exp_cnt = 12'hFFF;
        compared++;
        if ({EMPTY, OVFL, L1A_CNT} !== {1'b1, 1'b0, 12'hFFF}) begin
            mismatched++;
            $display("FAIL t6_preload got E%b O%b N%0d want E1 O0 N4095", EMPTY, OVFL, L1A_CNT);
        end
        l1a_event(6'h2A, 4, 1'b1);
        compared++;
        if (L1A_CNT !== exp_cnt) begin
            mismatched++;
            $display("FAIL t6_cnt_wrap got %0d want %0d", L1A_CNT, exp_cnt);
        end
        exp_e = sb.pop_front();
        compared++;
        if ({EMPTY, DOUT_MATCH, DOUT_L1ANUM} !== {1'b0, exp_e}) begin
            mismatched++;
            $display("FAIL t6_tag4095 got E%b %h/%0d want %h/%0d", EMPTY, DOUT_MATCH, DOUT_L1ANUM, exp_e[17:12], exp_e[11:0]);
        end
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        L1A = 1'b1;
        L1A_MATCH = 6'h3F;
        repeat (20) tick();
        L1A = 1'b0;
        L1A_MATCH = '0;
        tick();
        compared++;
        if ({FULL, OVFL} !== 2'b11) begin
            mismatched++;
            $display("FAIL t6_pre_rst got F%b O%b want F1 O1", FULL, OVFL);
        end
        do_reset();
        repeat (4) tick();
        compared++;
        if ({EMPTY, OVFL, COUNT, L1A_CNT, DOUT_MATCH, DOUT_L1ANUM} !== {1'b1, 1'b0, 5'd0, 12'd0, 6'd0, 12'd0}) begin
            mismatched++;
            $display("FAIL t6_mid_window_rst got E%b O%b C%0d N%0d D%h/%0d want E1 O0 C0 N0 D0/0", EMPTY, OVFL, COUNT, L1A_CNT, DOUT_MATCH, DOUT_L1ANUM);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_late_match();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
